// File: rtl/fpnew_pipe_in_skid.sv
// rtl/fpnew_pipe_in_skid.sv - Skid-buffered, bubble-collapsing input pipeline for an FPU operation unit
package fpnew_pkg;
    typedef enum logic [2:0] {
        RNE = 3'b000, RTZ = 3'b001, RDN = 3'b010, RUP = 3'b011,
        RMM = 3'b100, ROD = 3'b101, DYN = 3'b111
    } roundmode_e;

    typedef enum logic [3:0] {
        FMADD, FNMSUB, ADD, MUL, DIV, SQRT, SGNJ, MINMAX,
        CMP, CLASSIFY, F2F, F2I, I2F, CPKAB, CPKCD
    } operation_e;
endpackage

module fpnew_pipe_in_skid #(
    parameter int unsigned Width       = 32,
    parameter int unsigned NumOperands = 3,
    parameter int unsigned NumPipeRegs = 0,
    parameter type         TagType     = logic,
    parameter type         AuxType     = logic
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    input  logic [NumOperands-1:0][Width-1:0] operands_i,
    input  logic [NumOperands-1:0]            is_boxed_i,
    input  fpnew_pkg::roundmode_e             rnd_mode_i,
    input  fpnew_pkg::operation_e             op_i,
    input  logic                              op_mod_i,
    input  TagType                            tag_i,
    input  AuxType                            aux_i,
    input  logic                              in_valid_i,
    output logic                              in_ready_o,
    input  logic                              flush_i,
    output logic [NumOperands-1:0][Width-1:0] operands_o,
    output logic [NumOperands-1:0]            is_boxed_o,
    output fpnew_pkg::roundmode_e             rnd_mode_o,
    output fpnew_pkg::operation_e             op_o,
    output logic                              op_mod_o,
    output TagType                            tag_o,
    output AuxType                            aux_o,
    output logic                              out_valid_o,
    input  logic                              out_ready_i,
    output logic                              busy_o,
    output logic [$clog2(NumPipeRegs+3)-1:0]  occupancy_o
);
    localparam int unsigned OccWidth = $clog2(NumPipeRegs + 3);

    typedef struct packed {
        logic [NumOperands-1:0][Width-1:0] operands;
        logic [NumOperands-1:0]            is_boxed;
        fpnew_pkg::roundmode_e             rnd_mode;
        fpnew_pkg::operation_e             op;
        logic                              op_mod;
        TagType                            tag;
        AuxType                            aux;
    } payload_t;

    payload_t in_pl, out_pl;
    payload_t h_q, h_d, k_q, k_d;
    logic     valid_h_q, valid_h_d, valid_k_q, valid_k_d;
    logic     rdy_down, h_adv, accept;

    assign in_pl = '{operands: operands_i, is_boxed: is_boxed_i, rnd_mode: rnd_mode_i,
                     op: op_i, op_mod: op_mod_i, tag: tag_i, aux: aux_i};

    // Ready toward the issue side comes straight from a flop: only an empty skid slot matters.
    assign in_ready_o = ~valid_k_q;
    assign accept     = in_valid_i & in_ready_o;
    assign h_adv      = valid_h_q & rdy_down;

    always_comb begin
        valid_h_d = valid_h_q;
        valid_k_d = valid_k_q;
        h_d       = h_q;
        k_d       = k_q;
        if (valid_k_q) begin
            if (h_adv) begin
                valid_h_d = 1'b1;
                h_d       = k_q;
                valid_k_d = 1'b0;
            end
        end else if (accept) begin
            if (!valid_h_q || h_adv) begin
                valid_h_d = 1'b1;
                h_d       = in_pl;
            end else begin
                valid_k_d = 1'b1;
                k_d       = in_pl;
            end
        end else if (!valid_h_q || h_adv) begin
            valid_h_d = 1'b0;
        end
        if (flush_i) begin
            valid_h_d = 1'b0;
            valid_k_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            valid_h_q <= 1'b0;
            valid_k_q <= 1'b0;
            h_q       <= '0;
            k_q       <= '0;
        end else begin
            valid_h_q <= valid_h_d;
            valid_k_q <= valid_k_d;
            h_q       <= h_d;
            k_q       <= k_d;
        end
    end

    if (NumPipeRegs == 0) begin : g_no_stages
        assign rdy_down    = out_ready_i;
        assign out_valid_o = valid_h_q;
        assign out_pl      = h_q;
        assign occupancy_o = OccWidth'(valid_h_q) + OccWidth'(valid_k_q);
    end else begin : g_stages
        logic     [NumPipeRegs-1:0] valid_q, valid_d, rdy;
        payload_t [NumPipeRegs-1:0] pl_q, pl_d;
        logic     [NumPipeRegs:0]   chain_v;
        payload_t [NumPipeRegs:0]   chain_pl;

        // Entry i of the chain feeds stage i; entry 0 is the head, the top entry is the output.
        assign chain_v  = {valid_q, valid_h_q};
        assign chain_pl = {pl_q, h_q};

        // A stage is ready if the output is ready or any stage at or after it is empty.
        always_comb begin : p_rdy
            logic acc;
            acc = out_ready_i;
            rdy = '0;
            for (int i = int'(NumPipeRegs) - 1; i >= 0; i--) begin
                acc    = acc | ~valid_q[i];
                rdy[i] = acc;
            end
        end

        always_comb begin
            valid_d = valid_q;
            pl_d    = pl_q;
            for (int i = 0; i < int'(NumPipeRegs); i++) begin
                if (rdy[i]) begin
                    valid_d[i] = chain_v[i];
                    if (chain_v[i]) pl_d[i] = chain_pl[i];
                end
            end
            if (flush_i) valid_d = '0;
        end

        always_ff @(posedge clk_i) begin
            if (!rst_ni) begin
                valid_q <= '0;
                pl_q    <= '0;
            end else begin
                valid_q <= valid_d;
                pl_q    <= pl_d;
            end
        end

        always_comb begin
            occupancy_o = OccWidth'(valid_h_q) + OccWidth'(valid_k_q);
            for (int i = 0; i < int'(NumPipeRegs); i++) begin
                occupancy_o = occupancy_o + OccWidth'(valid_q[i]);
            end
        end

        assign rdy_down    = rdy[0];
        assign out_valid_o = chain_v[NumPipeRegs];
        assign out_pl      = chain_pl[NumPipeRegs];
    end

    assign busy_o     = (occupancy_o != '0);
    assign operands_o = out_pl.operands;
    assign is_boxed_o = out_pl.is_boxed;
    assign rnd_mode_o = out_pl.rnd_mode;
    assign op_o       = out_pl.op;
    assign op_mod_o   = out_pl.op_mod;
    assign tag_o      = out_pl.tag;
    assign aux_o      = out_pl.aux;
endmodule

// File: tb/tb_fpnew_pipe_in_skid.sv
// tb/tb_fpnew_pipe_in_skid.sv - Directed and scoreboard bench for fpnew_pipe_in_skid (NumPipeRegs 2 and 0)
module tb_fpnew_pipe_in_skid;
    localparam int W = 32;
    localparam int N = 3;
    typedef logic [15:0] tag_t;
    typedef logic [3:0]  aux_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   vectors     = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    logic [N-1:0][W-1:0]   a_ops_i, a_ops_o;
    logic [N-1:0]          a_box_i, a_box_o;
    fpnew_pkg::roundmode_e a_rnd_i, a_rnd_o;
    fpnew_pkg::operation_e a_op_i, a_op_o;
    logic                  a_mod_i, a_mod_o;
    tag_t                  a_tag_i, a_tag_o;
    aux_t                  a_aux_i, a_aux_o;
    logic                  a_in_valid, a_in_ready, a_flush, a_out_valid, a_out_ready, a_busy;
    logic [2:0]            a_occ;

    logic [N-1:0][W-1:0]   b_ops_i, b_ops_o;
    logic [N-1:0]          b_box_i, b_box_o;
    fpnew_pkg::roundmode_e b_rnd_i, b_rnd_o;
    fpnew_pkg::operation_e b_op_i, b_op_o;
    logic                  b_mod_i, b_mod_o;
    tag_t                  b_tag_i, b_tag_o;
    aux_t                  b_aux_i, b_aux_o;
    logic                  b_in_valid, b_in_ready, b_flush, b_out_valid, b_out_ready, b_busy;
    logic [1:0]            b_occ;

    fpnew_pipe_in_skid #(.Width(W), .NumOperands(N), .NumPipeRegs(2), .TagType(tag_t), .AuxType(aux_t)) dut2 (
        .clk_i(clk), .rst_ni(rst_n), .operands_i(a_ops_i), .is_boxed_i(a_box_i), .rnd_mode_i(a_rnd_i),
        .op_i(a_op_i), .op_mod_i(a_mod_i), .tag_i(a_tag_i), .aux_i(a_aux_i), .in_valid_i(a_in_valid),
        .in_ready_o(a_in_ready), .flush_i(a_flush), .operands_o(a_ops_o), .is_boxed_o(a_box_o),
        .rnd_mode_o(a_rnd_o), .op_o(a_op_o), .op_mod_o(a_mod_o), .tag_o(a_tag_o), .aux_o(a_aux_o),
        .out_valid_o(a_out_valid), .out_ready_i(a_out_ready), .busy_o(a_busy), .occupancy_o(a_occ));

    fpnew_pipe_in_skid #(.Width(W), .NumOperands(N), .NumPipeRegs(0), .TagType(tag_t), .AuxType(aux_t)) dut0 (
        .clk_i(clk), .rst_ni(rst_n), .operands_i(b_ops_i), .is_boxed_i(b_box_i), .rnd_mode_i(b_rnd_i),
        .op_i(b_op_i), .op_mod_i(b_mod_i), .tag_i(b_tag_i), .aux_i(b_aux_i), .in_valid_i(b_in_valid),
        .in_ready_o(b_in_ready), .flush_i(b_flush), .operands_o(b_ops_o), .is_boxed_o(b_box_o),
        .rnd_mode_o(b_rnd_o), .op_o(b_op_o), .op_mod_o(b_mod_o), .tag_o(b_tag_o), .aux_o(b_aux_o),
        .out_valid_o(b_out_valid), .out_ready_i(b_out_ready), .busy_o(b_busy), .occupancy_o(b_occ));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) step();
        vectors++; if (a_out_valid !== 1'b0) begin miscompares++; $display("FAIL rst_out_valid: got %b expected 0", a_out_valid); end
        vectors++; if (a_busy !== 1'b0) begin miscompares++; $display("FAIL rst_busy: got %b expected 0", a_busy); end
        vectors++; if (a_occ !== 3'd0) begin miscompares++; $display("FAIL rst_occ: got %0d expected 0", a_occ); end
        vectors++; if (a_in_ready !== 1'b1) begin miscompares++; $display("FAIL rst_in_ready: got %b expected 1", a_in_ready); end
        vectors++; if (a_ops_o !== '0 || a_tag_o !== '0 || a_aux_o !== '0) begin miscompares++; $display("FAIL rst_payload: got ops %h tag %h expected 0", a_ops_o, a_tag_o); end
        vectors++; if (b_out_valid !== 1'b0 || b_in_ready !== 1'b1 || b_occ !== 2'd0) begin miscompares++; $display("FAIL rst_npr0: got valid %b ready %b occ %0d expected 0/1/0", b_out_valid, b_in_ready, b_occ); end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_latency();
        logic [N-1:0][W-1:0] exp_ops;
        exp_ops     = {32'hCCCC_0003, 32'hBBBB_0002, 32'hAAAA_0001};
        a_out_ready = 1'b1;
        a_ops_i     = exp_ops;
        a_tag_i     = 16'd5;
        a_rnd_i     = fpnew_pkg::RMM;
        a_op_i      = fpnew_pkg::MUL;
        a_mod_i     = 1'b1;
        a_box_i     = 3'b101;
        a_aux_i     = 4'h9;
        a_in_valid  = 1'b1;
        step();
        a_in_valid = 1'b0;
        a_ops_i    = '0;
        a_tag_i    = '0;
        for (int c = 1; c <= 4; c++) begin
            vectors++; if (a_occ !== ((c <= 3) ? 3'd1 : 3'd0)) begin miscompares++; $display("FAIL lat_occ_c%0d: got %0d expected %0d", c, a_occ, (c <= 3) ? 1 : 0); end
            vectors++; if (a_out_valid !== (c == 3)) begin miscompares++; $display("FAIL lat_valid_c%0d: got %b expected %b", c, a_out_valid, c == 3); end
            if (c == 3) begin
                vectors++; if (a_ops_o !== exp_ops) begin miscompares++; $display("FAIL lat_ops: got %h expected %h", a_ops_o, exp_ops); end
                vectors++; if (a_tag_o !== 16'd5) begin miscompares++; $display("FAIL lat_tag: got %0d expected 5", a_tag_o); end
                vectors++; if (a_rnd_o !== fpnew_pkg::RMM || a_op_o !== fpnew_pkg::MUL || a_mod_o !== 1'b1 || a_box_o !== 3'b101 || a_aux_o !== 4'h9) begin
                    miscompares++; $display("FAIL lat_fields: got rnd %0d op %0d mod %b box %b aux %h expected 4 3 1 101 9", a_rnd_o, a_op_o, a_mod_o, a_box_o, a_aux_o);
                end
            end
            if (c < 4) step();
        end
    endtask

    task automatic test_back_to_back();
        int nxt = 0, accepts = 0, fourth = -1, late_ready = 0, got = 0, ord_err = 0, gaps = 0;
        logic acc;
        a_out_ready = 1'b0;
        a_in_valid  = 1'b1;
        a_tag_i     = tag_t'(nxt);
        for (int c = 0; c < 8; c++) begin
            acc = a_in_valid && a_in_ready;
            step();
            if (acc) begin
                nxt++;
                accepts++;
                if (accepts == 4) fourth = c;
            end
            if (fourth >= 0 && a_in_ready !== 1'b0) late_ready++;
            a_tag_i = tag_t'(nxt);
        end
        vectors++; if (accepts !== 4) begin miscompares++; $display("FAIL bp_accepts: got %0d expected 4", accepts); end
        vectors++; if (late_ready !== 0) begin miscompares++; $display("FAIL bp_ready_low: got %0d ready-high samples expected 0", late_ready); end
        vectors++; if (a_occ !== 3'd4) begin miscompares++; $display("FAIL bp_occ: got %0d expected 4", a_occ); end
        vectors++; if (a_out_valid !== 1'b1 || a_tag_o !== 16'd0) begin miscompares++; $display("FAIL bp_hold: got valid %b tag %0d expected 1 0", a_out_valid, a_tag_o); end
        a_out_ready = 1'b1;
        for (int c = 0; c < 40 && got < 10; c++) begin
            acc = a_in_valid && a_in_ready;
            if (a_out_valid) begin
                if (a_tag_o !== tag_t'(got)) ord_err++;
                got++;
            end else if (got > 0) begin
                gaps++;
            end
            step();
            if (acc) nxt++;
            a_in_valid = (nxt < 10);
            a_tag_i    = tag_t'(nxt);
        end
        a_in_valid = 1'b0;
        vectors++; if (got !== 10) begin miscompares++; $display("FAIL bp_count: got %0d expected 10", got); end
        vectors++; if (ord_err !== 0) begin miscompares++; $display("FAIL bp_order: got %0d out-of-order expected 0", ord_err); end
        vectors++; if (gaps !== 0) begin miscompares++; $display("FAIL bp_gaps: got %0d gaps expected 0", gaps); end
    endtask

    task automatic test_bubble();
        a_out_ready = 1'b0;
        for (int c = 0; c < 12; c++) begin
            a_in_valid = (c % 2 == 0);
            a_tag_i    = tag_t'(30 + c);
            step();
        end
        a_in_valid = 1'b0;
        vectors++; if (a_occ !== 3'd4) begin miscompares++; $display("FAIL bubble_occ: got %0d expected 4", a_occ); end
        vectors++; if (a_in_ready !== 1'b0 || a_busy !== 1'b1) begin miscompares++; $display("FAIL bubble_flags: got ready %b busy %b expected 0 1", a_in_ready, a_busy); end
        vectors++; if (a_tag_o !== 16'd30) begin miscompares++; $display("FAIL bubble_head: got %0d expected 30", a_tag_o); end
    endtask

    task automatic test_flush();
        int seen = 0;
        a_flush = 1'b1;
        step();
        a_flush     = 1'b0;
        a_out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            a_in_valid = 1'b1;
            a_tag_i    = tag_t'(20 + c);
            step();
        end
        vectors++; if (a_occ !== 3'd3 || a_in_ready !== 1'b1) begin miscompares++; $display("FAIL flush_pre: got occ %0d ready %b expected 3 1", a_occ, a_in_ready); end
        a_tag_i = 16'd23;
        a_flush = 1'b1;
        step();
        a_flush    = 1'b0;
        a_in_valid = 1'b0;
        vectors++; if (a_out_valid !== 1'b0 || a_occ !== 3'd0 || a_busy !== 1'b0 || a_in_ready !== 1'b1) begin
            miscompares++; $display("FAIL flush_state: got valid %b occ %0d busy %b ready %b expected 0 0 0 1", a_out_valid, a_occ, a_busy, a_in_ready);
        end
        a_out_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            if (a_out_valid) seen++;
            step();
        end
        vectors++; if (seen !== 0) begin miscompares++; $display("FAIL flush_leak: got %0d outputs expected 0", seen); end
    endtask

    task automatic test_random_npr0();
        int   q[$];
        int   sent = 0, rcvd = 0, errs = 0, rdy_errs = 0, exp_i;
        logic acc, fire, r;
        for (int cyc = 0; cyc < 20000 && rcvd < 1000; cyc++) begin
            r           = b_in_ready;
            b_in_valid  = (sent < 1000) && ($urandom_range(0, 3) != 0);
            b_ops_i     = {32'(sent * 5 + 1), 32'(~sent), 32'(sent * 3)};
            b_tag_i     = tag_t'(sent);
            b_out_ready = ($urandom_range(0, 2) != 0);
            #1;
            if (b_in_ready !== r) rdy_errs++;
            acc  = b_in_valid && b_in_ready;
            fire = b_out_valid && b_out_ready;
            if (fire) begin
                if (q.size() == 0) begin
                    errs++;
                end else begin
                    exp_i = q.pop_front();
                    if (b_tag_o !== tag_t'(exp_i) || b_ops_o[0] !== 32'(exp_i * 3) || b_ops_o[2] !== 32'(exp_i * 5 + 1)) errs++;
                end
                rcvd++;
            end
            if (acc) begin
                q.push_back(sent);
                sent++;
            end
            @(posedge clk);
            #1;
        end
        b_in_valid = 1'b0;
        vectors++; if (rcvd !== 1000) begin miscompares++; $display("FAIL rnd_count: got %0d expected 1000", rcvd); end
        vectors++; if (errs !== 0) begin miscompares++; $display("FAIL rnd_scoreboard: got %0d errors expected 0", errs); end
        vectors++; if (rdy_errs !== 0) begin miscompares++; $display("FAIL rnd_ready_comb: got %0d changes expected 0", rdy_errs); end
    endtask

    task automatic test_reset_midstream();
        a_out_ready = 1'b0;
        for (int c = 0; c < 4; c++) begin
            a_in_valid = 1'b1;
            a_tag_i    = tag_t'(40 + c);
            a_ops_i    = {3{32'(40 + c)}};
            step();
        end
        vectors++; if (a_in_ready !== 1'b0 || a_occ !== 3'd4) begin miscompares++; $display("FAIL rmid_full: got ready %b occ %0d expected 0 4", a_in_ready, a_occ); end
        a_tag_i = 16'd99;
        rst_n   = 1'b0;
        step();
        vectors++; if (a_out_valid !== 1'b0 || a_occ !== 3'd0 || a_busy !== 1'b0 || a_in_ready !== 1'b1) begin
            miscompares++; $display("FAIL rmid_flags: got valid %b occ %0d busy %b ready %b expected 0 0 0 1", a_out_valid, a_occ, a_busy, a_in_ready);
        end
        vectors++; if (a_ops_o !== '0 || a_tag_o !== '0) begin miscompares++; $display("FAIL rmid_payload: got ops %h tag %0d expected 0", a_ops_o, a_tag_o); end
        rst_n       = 1'b1;
        a_tag_i     = 16'd77;
        a_out_ready = 1'b1;
        step();
        a_in_valid = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            vectors++; if (a_out_valid !== (c == 3)) begin miscompares++; $display("FAIL rmid_lat_c%0d: got %b expected %b", c, a_out_valid, c == 3); end
            if (c == 3) begin
                vectors++; if (a_tag_o !== 16'd77) begin miscompares++; $display("FAIL rmid_tag: got %0d expected 77", a_tag_o); end
            end
            if (c < 3) step();
        end
    endtask

    initial begin
        a_ops_i = '0; a_box_i = '0; a_rnd_i = fpnew_pkg::RNE; a_op_i = fpnew_pkg::FMADD; a_mod_i = 1'b0;
        a_tag_i = '0; a_aux_i = '0; a_in_valid = 1'b0; a_flush = 1'b0; a_out_ready = 1'b0;
        b_ops_i = '0; b_box_i = '0; b_rnd_i = fpnew_pkg::RTZ; b_op_i = fpnew_pkg::ADD; b_mod_i = 1'b0;
        b_tag_i = '0; b_aux_i = '0; b_in_valid = 1'b0; b_flush = 1'b0; b_out_ready = 1'b0;
        #1;
        test_reset();
        test_latency();
        test_back_to_back();
        test_bubble();
        test_flush();
        test_random_npr0();
        test_reset_midstream();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
